mesi_isc_cbus_resp: RTL and testbench

Per-CPU coherence-bus responder: the CPU-side end of the MESI ISC coherence bus. Accepts one 3-bit command lane from the broadcast controller, looks up a local direct-mapped MESI state table, and updates the line state. Dirty data is flushed through a writeback handshake before the single-cycle acknowledge is returned. Four instances, one per CPU, sit between the ISC and the CPU caches.

---
 rtl/mesi_isc_cbus_resp.sv | 236 +++++++++++++++++++++++
 tb/tb_mesi_isc_cbus_resp.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_isc_cbus_resp.sv
// mesi_isc_cbus_resp: per-CPU end of the MESI ISC coherence bus.
// Takes one command lane from the broadcast controller, updates a local
// direct-mapped MESI state table, and flushes dirty lines through a
// writeback handshake before issuing a single-cycle acknowledge.
module mesi_isc_cbus_resp #(
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int INDEX_WIDTH    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
    output logic                      cbus_ack_o,
    output logic                      wb_req_o,
    output logic [ADDR_WIDTH-1:0]     wb_addr_o,
    input  logic                      wb_ack_i,
    input  logic [ADDR_WIDTH-1:0]     lookup_addr_i,
    output logic [1:0]                lookup_state_o
);

    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
    localparam int ENTRIES   = 1 << INDEX_WIDTH;

    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_NOP      = CBUS_CMD_WIDTH'(0);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_E = 2'd2;
    localparam logic [1:0] ST_M = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB,
        ACK,
        WAIT_NOP
    } fsm_t;

    fsm_t                      fsm_q, fsm_d;
    logic [CBUS_CMD_WIDTH-1:0] cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [TAG_WIDTH-1:0]      upd_tag_q, upd_tag_d;
    logic [1:0]                upd_st_q, upd_st_d;
    logic                      ack_q, ack_d;
    logic                      wb_req_q, wb_req_d;
    logic [ADDR_WIDTH-1:0]     wb_addr_q, wb_addr_d;

    logic [1:0]                st_tbl_q  [ENTRIES];
    logic [1:0]                st_tbl_d  [ENTRIES];
    logic [TAG_WIDTH-1:0]      tag_tbl_q [ENTRIES];
    logic [TAG_WIDTH-1:0]      tag_tbl_d [ENTRIES];

    logic [INDEX_WIDTH-1:0]    cur_idx;
    logic [TAG_WIDTH-1:0]      cur_tag;
    logic [TAG_WIDTH-1:0]      ent_tag;
    logic [1:0]                ent_st;
    logic                      tag_hit;
    logic                      hit;
    logic [TAG_WIDTH-1:0]      new_tag;
    logic [1:0]                new_st;
    logic                      need_wb;
    logic [ADDR_WIDTH-1:0]     victim_addr;
    logic                      wb_accept;
    logic                      commit;
    logic [TAG_WIDTH-1:0]      commit_tag;
    logic [1:0]                commit_st;
    logic [INDEX_WIDTH-1:0]    lk_idx;
    logic [TAG_WIDTH-1:0]      lk_tag;

    assign cur_idx     = addr_q[INDEX_WIDTH-1:0];
    assign cur_tag     = addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
    assign ent_tag     = tag_tbl_q[cur_idx];
    assign ent_st      = st_tbl_q[cur_idx];
    assign tag_hit     = (ent_tag == cur_tag);
    assign hit         = (ent_st != ST_I) && tag_hit;
    assign victim_addr = {ent_tag, cur_idx};

    // The writeback handshake completes only once the request is visible on the bus.
    assign wb_accept   = (fsm_q == WB) && wb_req_q && wb_ack_i;

    // Table update lands either straight out of LOOKUP or when the victim flush is accepted.
    assign commit      = ((fsm_q == LOOKUP) && !need_wb) || wb_accept;
    assign commit_tag  = (fsm_q == WB) ? upd_tag_q : new_tag;
    assign commit_st   = (fsm_q == WB) ? upd_st_q  : new_st;

    assign cbus_ack_o  = ack_q;
    assign wb_req_o    = wb_req_q;
    assign wb_addr_o   = wb_addr_q;

    // MESI transition for the latched command against the current table entry.
    always_comb begin
        new_tag = ent_tag;
        new_st  = ent_st;
        need_wb = 1'b0;
        case (cmd_q)
            CMD_RD_SNOOP: begin
                if (hit) begin
                    new_st  = ST_S;
                    need_wb = (ent_st == ST_M);
                end
            end
            CMD_WR_SNOOP: begin
                if (hit) begin
                    new_st  = ST_I;
                    need_wb = (ent_st == ST_M);
                end
            end
            CMD_EN_WR: begin
                new_tag = cur_tag;
                new_st  = ST_M;
                need_wb = (ent_st == ST_M) && !tag_hit;
            end
            CMD_EN_RD: begin
                new_tag = cur_tag;
                need_wb = (ent_st == ST_M) && !tag_hit;
                if (hit && ((ent_st == ST_M) || (ent_st == ST_E))) begin
                    new_st = ent_st;
                end else begin
                    new_st = ST_S;
                end
            end
            default: begin
                new_tag = ent_tag;
            end
        endcase
    end

    // Next-state and registered-output logic for the command handshake.
    always_comb begin
        fsm_d     = fsm_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        upd_tag_d = upd_tag_q;
        upd_st_d  = upd_st_q;
        wb_addr_d = wb_addr_q;
        ack_d     = 1'b0;
        wb_req_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (cbus_cmd_i inside {CMD_WR_SNOOP, CMD_RD_SNOOP, CMD_EN_WR, CMD_EN_RD}) begin
                    cmd_d  = cbus_cmd_i;
                    addr_d = cbus_addr_i;
                    fsm_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                upd_tag_d = new_tag;
                upd_st_d  = new_st;
                if (need_wb) begin
                    wb_addr_d = victim_addr;
                    fsm_d     = WB;
                end else begin
                    fsm_d     = ACK;
                end
            end
            WB: begin
                if (wb_accept) begin
                    ack_d = 1'b1;
                    fsm_d = ACK;
                end else begin
                    wb_req_d = 1'b1;
                end
            end
            ACK: begin
                ack_d = !ack_q;
                fsm_d = WAIT_NOP;
            end
            WAIT_NOP: begin
                if (cbus_cmd_i == CMD_NOP) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // Write the committed entry into the next-cycle view of the table.
    always_comb begin
        st_tbl_d  = st_tbl_q;
        tag_tbl_d = tag_tbl_q;
        if (commit) begin
            st_tbl_d[cur_idx]  = commit_st;
            tag_tbl_d[cur_idx] = commit_tag;
        end
    end

    // Control state and line states, cleared asynchronously so a reset abandons any command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            cmd_q     <= CMD_NOP;
            addr_q    <= '0;
            upd_tag_q <= '0;
            upd_st_q  <= ST_I;
            ack_q     <= 1'b0;
            wb_req_q  <= 1'b0;
            wb_addr_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                st_tbl_q[i] <= ST_I;
            end
        end else begin
            fsm_q     <= fsm_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            upd_tag_q <= upd_tag_d;
            upd_st_q  <= upd_st_d;
            ack_q     <= ack_d;
            wb_req_q  <= wb_req_d;
            wb_addr_q <= wb_addr_d;
            st_tbl_q  <= st_tbl_d;
        end
    end

    // Tags are meaningless while the state is I, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_tbl_q <= tag_tbl_d;
    end

    // CPU-side probe: report the stored state only when the line is valid and the tag matches.
    always_comb begin
        lk_idx = lookup_addr_i[INDEX_WIDTH-1:0];
        lk_tag = lookup_addr_i[ADDR_WIDTH-1:INDEX_WIDTH];
        lookup_state_o = ST_I;
        if ((st_tbl_q[lk_idx] != ST_I) && (tag_tbl_q[lk_idx] == lk_tag)) begin
            lookup_state_o = st_tbl_q[lk_idx];
        end
    end

endmodule

// File: tb/tb_mesi_isc_cbus_resp.sv
// Directed bench for mesi_isc_cbus_resp: expected handshake timing is queued
// when each command is issued and compared once the responder acks.
module tb_mesi_isc_cbus_resp;

    localparam logic [2:0] CMD_NOP      = 3'd0;
    localparam logic [2:0] CMD_WR_SNOOP = 3'd1;
    localparam logic [2:0] CMD_RD_SNOOP = 3'd2;
    localparam logic [2:0] CMD_EN_WR    = 3'd3;
    localparam logic [2:0] CMD_EN_RD    = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  cbus_cmd_i = CMD_NOP;
    logic [31:0] cbus_addr_i = '0;
    logic        cbus_ack_o;
    logic        wb_req_o;
    logic [31:0] wb_addr_o;
    logic        wb_ack_i = 1'b0;
    logic [31:0] lookup_addr_i = '0;
    logic [1:0]  lookup_state_o;

    typedef struct {
        bit          wb;
        logic [31:0] wbAddr;
        int          wbLat;
        int          ackLat;
    } expItem_t;

    expItem_t expQ[$];
    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    mesi_isc_cbus_resp #(
        .CBUS_CMD_WIDTH(3),
        .ADDR_WIDTH(32),
        .INDEX_WIDTH(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cbus_cmd_i(cbus_cmd_i),
        .cbus_addr_i(cbus_addr_i),
        .cbus_ack_o(cbus_ack_o),
        .wb_req_o(wb_req_o),
        .wb_addr_o(wb_addr_o),
        .wb_ack_i(wb_ack_i),
        .lookup_addr_i(lookup_addr_i),
        .lookup_state_o(lookup_state_o)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Hard stop in case the stimulus itself wedges.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", passCount, checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkLookup(input logic [31:0] addr, input logic [1:0] expected);
        lookup_addr_i = addr;
        #1;
        check($sformatf("lookup 0x%0h", addr), {30'd0, lookup_state_o}, {30'd0, expected});
    endtask

    task automatic checkOutput(input string name, input int ackCount, input int ackCyc,
                               input int wbCyc, input logic [31:0] wbAddr);
        expItem_t item;
        item = expQ.pop_front();
        check({name, " ack pulses"}, ackCount, 1);
        check({name, " ack latency"}, ackCyc, item.ackLat);
        check({name, " wb_req seen"}, {31'd0, (wbCyc >= 0)}, {31'd0, item.wb});
        if (item.wb) begin
            check({name, " wb_req latency"}, wbCyc, item.wbLat);
            check({name, " wb_addr"}, wbAddr, item.wbAddr);
        end
    endtask

    // Issue one command, play the writeback side with the requested stall,
    // hold the command for holdCycles after the ack, then score the result.
    task automatic applyStimulus(input string name, input logic [2:0] cmd, input logic [31:0] addr,
                                 input bit expWb, input logic [31:0] expWbAddr,
                                 input int wbStall, input int holdCycles);
        expItem_t    item;
        int          cyc = 0;
        int          ackCount = 0;
        int          ackCyc = -1;
        int          wbCyc = -1;
        int          stall = wbStall;
        int          dropAt = -1;
        logic [31:0] seenWbAddr = '0;
        item.wb     = expWb;
        item.wbAddr = expWbAddr;
        item.wbLat  = 3;
        item.ackLat = expWb ? (4 + wbStall) : 3;
        expQ.push_back(item);
        cbus_cmd_i  = cmd;
        cbus_addr_i = addr;
        wb_ack_i    = 1'b0;
        while (cyc < 40) begin
            tick();
            cyc++;
            if (cbus_ack_o) begin
                ackCount++;
                if (ackCyc < 0) begin
                    ackCyc = cyc;
                    dropAt = cyc + holdCycles;
                end
            end
            if (wb_req_o) begin
                if (wbCyc < 0) begin
                    wbCyc = cyc;
                    seenWbAddr = wb_addr_o;
                end
                if (stall > 0) begin
                    stall--;
                    wb_ack_i = 1'b0;
                end else begin
                    wb_ack_i = 1'b1;
                end
            end else begin
                wb_ack_i = 1'b0;
            end
            if (dropAt >= 0 && cyc >= dropAt) cbus_cmd_i = CMD_NOP;
            if (dropAt >= 0 && cyc >= dropAt + 3) break;
        end
        wb_ack_i   = 1'b0;
        cbus_cmd_i = CMD_NOP;
        checkOutput(name, ackCount, ackCyc, wbCyc, seenWbAddr);
    endtask

    // Directed sequence.
    initial begin
        int badAcks;
        int badWbs;
        int waitCyc;

        $display("[TB] start");
        #1;
        check("reset cbus_ack_o", {31'd0, cbus_ack_o}, 0);
        check("reset wb_req_o", {31'd0, wb_req_o}, 0);
        check("reset wb_addr_o", wb_addr_o, 0);
        checkLookup(32'h40, 2'd0);
        tick();
        tick();
        rst_n = 1'b1;

        applyStimulus("rd_snoop empty", CMD_RD_SNOOP, 32'h40, 1'b0, 32'h0, 0, 0);
        checkLookup(32'h40, 2'd0);

        applyStimulus("en_wr 0x40", CMD_EN_WR, 32'h40, 1'b0, 32'h0, 0, 0);
        checkLookup(32'h40, 2'd3);

        applyStimulus("rd_snoop M", CMD_RD_SNOOP, 32'h40, 1'b1, 32'h40, 3, 0);
        checkLookup(32'h40, 2'd1);

        applyStimulus("en_rd S hit", CMD_EN_RD, 32'h40, 1'b0, 32'h0, 0, 0);
        checkLookup(32'h40, 2'd1);

        applyStimulus("wr_snoop alias miss", CMD_WR_SNOOP, 32'h48, 1'b0, 32'h0, 0, 0);
        checkLookup(32'h40, 2'd1);

        applyStimulus("wr_snoop S", CMD_WR_SNOOP, 32'h40, 1'b0, 32'h0, 0, 0);
        checkLookup(32'h40, 2'd0);

        applyStimulus("en_wr held cmd", CMD_EN_WR, 32'h40, 1'b0, 32'h0, 0, 3);
        checkLookup(32'h40, 2'd3);

        applyStimulus("en_rd victim", CMD_EN_RD, 32'h48, 1'b1, 32'h40, 0, 0);
        checkLookup(32'h48, 2'd1);
        checkLookup(32'h40, 2'd0);

        applyStimulus("en_wr idx1", CMD_EN_WR, 32'h41, 1'b0, 32'h0, 0, 0);
        checkLookup(32'h41, 2'd3);
        checkLookup(32'h49, 2'd0);

        // Undefined command code must never be acknowledged.
        badAcks = 0;
        badWbs = 0;
        cbus_cmd_i  = 3'b111;
        cbus_addr_i = 32'h41;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cbus_ack_o) badAcks++;
            if (wb_req_o) badWbs++;
        end
        cbus_cmd_i = CMD_NOP;
        check("undefined cmd acks", badAcks, 0);
        check("undefined cmd wb_req", badWbs, 0);
        checkLookup(32'h41, 2'd3);

        // Reset while a victim writeback is outstanding.
        cbus_cmd_i  = CMD_EN_WR;
        cbus_addr_i = 32'h49;
        waitCyc = 0;
        while (!wb_req_o && waitCyc < 20) begin
            tick();
            waitCyc++;
        end
        check("wb_req before reset", {31'd0, wb_req_o}, 1);
        check("wb_addr before reset", wb_addr_o, 32'h41);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset in WB wb_req_o", {31'd0, wb_req_o}, 0);
        check("reset in WB cbus_ack_o", {31'd0, cbus_ack_o}, 0);
        check("reset in WB wb_addr_o", wb_addr_o, 0);
        cbus_cmd_i = CMD_NOP;
        tick();
        tick();
        rst_n = 1'b1;
        checkLookup(32'h41, 2'd0);
        checkLookup(32'h48, 2'd0);
        checkLookup(32'h49, 2'd0);

        applyStimulus("rd_snoop after reset", CMD_RD_SNOOP, 32'h41, 1'b0, 32'h0, 0, 0);
        checkLookup(32'h41, 2'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
